// File: rtl/ula_dram_sched.sv
// rtl/ula_dram_sched.sv - ULA contended-DRAM slot scheduler for video fetch and CPU access
module ula_dram_sched #(
    parameter int ADDR_W = 14,
    parameter int ROW_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_active,
    input  logic [ADDR_W-1:0] vid_addr_bmp,
    input  logic [ADDR_W-1:0] vid_addr_attr,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              ras_n,
    output logic              cas_n,
    output logic              dram_we_n,
    output logic [ROW_W-1:0]  dram_addr,
    output logic [2:0]        slot_cnt,
    output logic              vid_bmp_strobe,
    output logic              vid_attr_strobe,
    output logic              cpu_ack,
    output logic              cpu_stall
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    logic [2:0]        slot_q, slot_d;
    logic              vid_en_q, vid_en_d;
    owner_e            owner_q, owner_d;
    logic              req_armed_q, req_armed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              ras_n_q, ras_n_d;
    logic              cas_n_q, cas_n_d;
    logic              we_n_q, we_n_d;
    logic [ROW_W-1:0]  dram_addr_q, dram_addr_d;
    logic              bmp_stb_q, bmp_stb_d;
    logic              attr_stb_q, attr_stb_d;
    logic              ack_q, ack_d;

    logic [1:0]        phase_d;
    logic              boundary;
    logic              active_d;
    logic [ROW_W-1:0]  row_d;
    logic [ROW_W-1:0]  col_d;

    // Slot position, video-enable latch and window-owner arbitration for the upcoming clock
    always_comb begin
        slot_d   = slot_q + 3'd1;
        phase_d  = slot_d[1:0];
        boundary = (phase_d == 2'd0);
        // vid_en is only refreshed on the 7->0 edge so it covers exactly one full slot
        vid_en_d = (slot_q == 3'd7) ? vid_active : vid_en_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        if (boundary) begin
            if (vid_en_d) begin
                owner_d = OWN_VID;
                addr_d  = slot_d[2] ? vid_addr_attr : vid_addr_bmp;
                wr_d    = 1'b0;
            end else if (cpu_req && req_armed_q) begin
                owner_d = OWN_CPU;
                addr_d  = cpu_addr;
                wr_d    = cpu_wr;
            end else begin
                owner_d = OWN_IDLE;
            end
        end
        row_d = addr_d[ROW_W-1:0];
        col_d = ROW_W'(addr_d >> ROW_W);
    end

    // DRAM strobe/address sequencing and data-valid pulses for the phase being entered
    always_comb begin
        active_d    = (owner_d != OWN_IDLE);
        ras_n_d     = 1'b1;
        cas_n_d     = 1'b1;
        we_n_d      = 1'b1;
        dram_addr_d = dram_addr_q;
        bmp_stb_d   = 1'b0;
        attr_stb_d  = 1'b0;
        ack_d       = 1'b0;
        if (active_d) begin
            case (phase_d)
                2'd0: begin
                    ras_n_d     = 1'b0;
                    dram_addr_d = row_d;
                end
                2'd1, 2'd2: begin
                    ras_n_d     = 1'b0;
                    cas_n_d     = 1'b0;
                    we_n_d      = ~wr_d;
                    dram_addr_d = col_d;
                end
                default: begin
                    // precharge: strobes released, column address left on the bus
                    dram_addr_d = col_d;
                end
            endcase
            if (phase_d == 2'd2) begin
                bmp_stb_d  = (owner_d == OWN_VID) && !slot_d[2];
                attr_stb_d = (owner_d == OWN_VID) && slot_d[2];
                ack_d      = (owner_d == OWN_CPU);
            end
        end
        // a request held past its ack stays disarmed until the CPU lets go for a clock
        if (ack_d) begin
            req_armed_d = 1'b0;
        end else if (!cpu_req) begin
            req_armed_d = 1'b1;
        end else begin
            req_armed_d = req_armed_q;
        end
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= 3'd0;
            vid_en_q    <= 1'b0;
            owner_q     <= OWN_IDLE;
            req_armed_q <= 1'b1;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            we_n_q      <= 1'b1;
            dram_addr_q <= '0;
            bmp_stb_q   <= 1'b0;
            attr_stb_q  <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            vid_en_q    <= vid_en_d;
            owner_q     <= owner_d;
            req_armed_q <= req_armed_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            ras_n_q     <= ras_n_d;
            cas_n_q     <= cas_n_d;
            we_n_q      <= we_n_d;
            dram_addr_q <= dram_addr_d;
            bmp_stb_q   <= bmp_stb_d;
            attr_stb_q  <= attr_stb_d;
            ack_q       <= ack_d;
        end
    end

    assign ras_n           = ras_n_q;
    assign cas_n           = cas_n_q;
    assign dram_we_n       = we_n_q;
    assign dram_addr       = dram_addr_q;
    assign slot_cnt        = slot_q;
    assign vid_bmp_strobe  = bmp_stb_q;
    assign vid_attr_strobe = attr_stb_q;
    assign cpu_ack         = ack_q;
    // CPU clock is held while it wants the bank but the current window belongs to someone else
    assign cpu_stall       = cpu_req & req_armed_q & (owner_q != OWN_CPU);

endmodule

// File: tb/tb_ula_dram_sched.sv
// tb/tb_ula_dram_sched.sv - self-checking bench for ula_dram_sched
module tb_ula_dram_sched;

    localparam int ADDR_W = 14;
    localparam int ROW_W  = 7;
    localparam int NV     = 37;

    logic              clk;
    logic              rst;
    logic              vid_active;
    logic [ADDR_W-1:0] vid_addr_bmp;
    logic [ADDR_W-1:0] vid_addr_attr;
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic              ras_n;
    logic              cas_n;
    logic              dram_we_n;
    logic [ROW_W-1:0]  dram_addr;
    logic [2:0]        slot_cnt;
    logic              vid_bmp_strobe;
    logic              vid_attr_strobe;
    logic              cpu_ack;
    logic              cpu_stall;

    int n_chk = 0;
    int n_err = 0;

    ula_dram_sched #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .vid_active      (vid_active),
        .vid_addr_bmp    (vid_addr_bmp),
        .vid_addr_attr   (vid_addr_attr),
        .cpu_req         (cpu_req),
        .cpu_wr          (cpu_wr),
        .cpu_addr        (cpu_addr),
        .ras_n           (ras_n),
        .cas_n           (cas_n),
        .dram_we_n       (dram_we_n),
        .dram_addr       (dram_addr),
        .slot_cnt        (slot_cnt),
        .vid_bmp_strobe  (vid_bmp_strobe),
        .vid_attr_strobe (vid_attr_strobe),
        .cpu_ack         (cpu_ack),
        .cpu_stall       (cpu_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: decides each window's owner from the arbitration rules, then
    // derives the strobe pattern and row/column address from the phase within the window.
    int m_slot = 0;
    int m_own  = 0;       // 0 idle, 1 video, 2 cpu
    int m_addr = 0;
    bit m_wr   = 0;
    bit m_ven  = 0;
    bit m_armed = 1;
    bit e_ras = 1, e_cas = 1, e_we = 1, e_bs = 0, e_as = 0, e_ack = 0;
    int e_daddr = 0;
    int m_nxt, m_ph;
    bit m_acc;

    always @(posedge clk) begin
        if (rst) begin
            m_slot = 0; m_own = 0; m_addr = 0; m_wr = 0; m_ven = 0; m_armed = 1;
            e_ras = 1; e_cas = 1; e_we = 1; e_bs = 0; e_as = 0; e_ack = 0; e_daddr = 0;
        end else begin
            if (m_slot == 7) m_ven = vid_active;
            m_nxt = (m_slot + 1) % 8;
            m_ph  = m_nxt % 4;
            if (m_ph == 0) begin
                if (m_ven) begin
                    m_own = 1; m_wr = 0;
                    m_addr = (m_nxt < 4) ? int'(vid_addr_bmp) : int'(vid_addr_attr);
                end else if (cpu_req && m_armed) begin
                    m_own = 2; m_wr = cpu_wr; m_addr = int'(cpu_addr);
                end else begin
                    m_own = 0;
                end
            end
            m_acc = (m_own != 0);
            e_ras = !(m_acc && m_ph < 3);
            e_cas = !(m_acc && (m_ph == 1 || m_ph == 2));
            e_we  = !(m_own == 2 && m_wr && (m_ph == 1 || m_ph == 2));
            if (m_acc && m_ph == 0) e_daddr = m_addr % (1 << ROW_W);
            else if (m_acc && m_ph != 3) e_daddr = m_addr / (1 << ROW_W);
            e_bs  = (m_own == 1 && m_ph == 2 && m_nxt < 4);
            e_as  = (m_own == 1 && m_ph == 2 && m_nxt >= 4);
            e_ack = (m_own == 2 && m_ph == 2);
            if (e_ack) m_armed = 0;
            else if (!cpu_req) m_armed = 1;
            m_slot = m_nxt;
        end
    end

    typedef struct {
        logic       vid, req, wr;
        logic       ras, cas, we;
        logic [6:0] daddr;
        logic       bs, at, ack, st;
    } vec_t;

    vec_t tv [NV];

    function automatic vec_t row(input logic vid, req, wr, ras, cas, we,
                                 input logic [6:0] da, input logic bs, at, ack, st);
        vec_t v;
        v.vid = vid; v.req = req; v.wr = wr;
        v.ras = ras; v.cas = cas; v.we = we; v.daddr = da;
        v.bs = bs; v.at = at; v.ack = ack; v.st = st;
        return v;
    endfunction

    function automatic logic [15:0] pk(input logic [2:0] s, input logic r, c, w,
                                       input logic [6:0] d, input logic b, a, k, t);
        return {s, r, c, w, d, b, a, k, t};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] dut_vec();
        return pk(slot_cnt, ras_n, cas_n, dram_we_n, dram_addr,
                  vid_bmp_strobe, vid_attr_strobe, cpu_ack, cpu_stall);
    endfunction

    bit acked;
    int k;

    initial begin
        // idle slot (vid_active off-position ignored), video slot, idle CPU read, CPU write
        tv[0]  = row(0,0,0, 1,1,1,7'h00, 0,0,0,0);
        tv[1]  = row(0,0,0, 1,1,1,7'h00, 0,0,0,0);
        tv[2]  = row(1,0,0, 1,1,1,7'h00, 0,0,0,0);
        tv[3]  = row(0,0,0, 1,1,1,7'h00, 0,0,0,0);
        tv[4]  = row(0,0,0, 1,1,1,7'h00, 0,0,0,0);
        tv[5]  = row(0,0,0, 1,1,1,7'h00, 0,0,0,0);
        tv[6]  = row(0,0,0, 1,1,1,7'h00, 0,0,0,0);
        tv[7]  = row(1,0,0, 1,1,1,7'h00, 0,0,0,0);
        tv[8]  = row(0,0,0, 0,1,1,7'h05, 0,0,0,0);
        tv[9]  = row(0,0,0, 0,0,1,7'h34, 0,0,0,0);
        tv[10] = row(0,0,0, 0,0,1,7'h34, 1,0,0,0);
        tv[11] = row(0,0,0, 1,1,1,7'h34, 0,0,0,0);
        tv[12] = row(0,0,0, 0,1,1,7'h05, 0,0,0,0);
        tv[13] = row(0,0,0, 0,0,1,7'h36, 0,0,0,0);
        tv[14] = row(0,0,0, 0,0,1,7'h36, 0,1,0,0);
        tv[15] = row(0,0,0, 1,1,1,7'h36, 0,0,0,0);
        tv[16] = row(0,0,0, 1,1,1,7'h36, 0,0,0,0);
        tv[17] = row(0,1,0, 1,1,1,7'h36, 0,0,0,1);
        tv[18] = row(0,1,0, 1,1,1,7'h36, 0,0,0,1);
        tv[19] = row(0,1,0, 1,1,1,7'h36, 0,0,0,1);
        tv[20] = row(0,1,0, 0,1,1,7'h23, 0,0,0,0);
        tv[21] = row(0,1,0, 0,0,1,7'h02, 0,0,0,0);
        tv[22] = row(0,1,0, 0,0,1,7'h02, 0,0,1,0);
        tv[23] = row(0,0,0, 1,1,1,7'h02, 0,0,0,0);
        for (int i = 24; i <= 30; i++) tv[i] = row(0,0,0, 1,1,1,7'h02, 0,0,0,0);
        tv[31] = row(0,1,1, 1,1,1,7'h02, 0,0,0,1);
        tv[32] = row(0,1,1, 0,1,1,7'h23, 0,0,0,0);
        tv[33] = row(0,1,1, 0,0,0,7'h02, 0,0,0,0);
        tv[34] = row(0,1,1, 0,0,0,7'h02, 0,0,1,0);
        tv[35] = row(0,0,0, 1,1,1,7'h02, 0,0,0,0);
        tv[36] = row(0,0,0, 1,1,1,7'h02, 0,0,0,0);

        rst = 1'b1; vid_active = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
        cpu_addr = 14'h0123; vid_addr_bmp = 14'h1A05; vid_addr_attr = 14'h1B05;
        adv();
        adv();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            vid_active = tv[i].vid; cpu_req = tv[i].req; cpu_wr = tv[i].wr;
            @(negedge clk);
            chk($sformatf("vec%0d", i), dut_vec(),
                pk(3'(i % 8), tv[i].ras, tv[i].cas, tv[i].we, tv[i].daddr,
                   tv[i].bs, tv[i].at, tv[i].ack, tv[i].st));
            adv();
        end

        // contention: request arrives during a video slot and waits for the next slot
        k = 0;
        while (slot_cnt != 3'd7 && k < 16) begin adv(); k++; end
        chk("align_7", 16'(slot_cnt), 16'd7);
        vid_active = 1'b1;
        adv();
        vid_active = 1'b0;
        adv(); adv(); adv();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h2A5F;
        for (int p = 3; p < 8; p++) begin
            @(negedge clk);
            chk($sformatf("cont_stall_p%0d", p), 16'({slot_cnt, cpu_stall}), 16'({3'(p), 1'b1}));
            adv();
        end
        @(negedge clk);
        chk("cont_row", 16'({slot_cnt, ras_n, dram_addr, cpu_stall}), 16'({3'd0, 1'b0, 7'h5F, 1'b0}));
        adv();
        @(negedge clk);
        chk("cont_col", 16'({cas_n, dram_we_n, dram_addr}), 16'({1'b0, 1'b1, 7'h54}));
        adv();
        @(negedge clk);
        chk("cont_ack", 16'({slot_cnt, cpu_ack}), 16'({3'd2, 1'b1}));
        adv();

        // held request after ack is not serviced again
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk($sformatf("held_quiet%0d", j), 16'({cpu_ack, cpu_stall, ras_n}), 16'(3'b001));
            adv();
        end
        cpu_req = 1'b0;
        adv();
        cpu_req = 1'b1;
        k = 0;
        while (slot_cnt[1:0] != 2'd0 && k < 8) begin adv(); k++; end
        @(negedge clk);
        chk("rearm_grant", 16'({slot_cnt[1:0], ras_n}), 16'({2'd0, 1'b0}));
        adv(); adv();
        @(negedge clk);
        chk("rearm_ack", 16'(cpu_ack), 16'd1);
        adv();
        cpu_req = 1'b0;
        adv();

        // reset in the middle of a CPU access
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h0777;
        k = 0;
        while (ras_n != 1'b0 && k < 16) begin adv(); k++; end
        chk("rst_find_access", 16'(ras_n), 16'd0);
        adv();
        rst = 1'b1; cpu_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            adv();
            @(negedge clk);
            chk($sformatf("rst_state%0d", j), dut_vec(),
                pk(3'd0, 1'b1, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        adv();
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("rst_no_resume%0d", j), 16'({cpu_ack, ras_n}), 16'(2'b01));
            adv();
        end

        // randomized traffic against the reference model
        acked = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            vid_active = ($urandom_range(0, 2) == 0);
            vid_addr_bmp = 14'($urandom);
            vid_addr_attr = 14'($urandom);
            if (rst) begin
                cpu_req = 1'b0; acked = 0;
            end else if (!cpu_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    cpu_req = 1'b1; cpu_wr = 1'($urandom_range(0, 1)); cpu_addr = 14'($urandom);
                end
            end else if (acked && $urandom_range(0, 1) == 0) begin
                cpu_req = 1'b0; acked = 0;
            end
            @(negedge clk);
            if (cpu_ack) acked = 1;
            chk("rand", dut_vec(),
                pk(3'(m_slot), e_ras, e_cas, e_we, 7'(e_daddr), e_bs, e_as, e_ack,
                   cpu_req && m_armed && (m_own != 2)));
            adv();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
